// File: rtl/fft_bfly_addsub_seq.sv
// fft_bfly_addsub_seq: sequences X=A+WB, Y=A-WB over one shared FP add/sub unit, four ops per butterfly
module fft_bfly_addsub_seq #(
   parameter int DATA_W  = 32,
   parameter int ADD_LAT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a_re,
   input  logic [DATA_W-1:0] a_im,
   input  logic [DATA_W-1:0] wb_re,
   input  logic [DATA_W-1:0] wb_im,
   output logic [DATA_W-1:0] add_a,
   output logic [DATA_W-1:0] add_b,
   output logic              add_sub,
   input  logic [DATA_W-1:0] add_res,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] x_re,
   output logic [DATA_W-1:0] x_im,
   output logic [DATA_W-1:0] y_re,
   output logic [DATA_W-1:0] y_im,
   output logic              busy
);
   localparam int CW = ADD_LAT > 0 ? $clog2(ADD_LAT + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'(ADD_LAT);
   typedef enum logic [2:0] {IDLE, OP0, OP1, OP2, OP3, DONE} state_t;
   state_t            state;
   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] ar, ai, br, bi;
   logic              last;
   assign last = cnt == LAST;
   // adder operands are loaded one op ahead so they are already stable on the first cycle of each op
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         cnt       <= '0;
         add_a     <= '0;
         add_b     <= '0;
         add_sub   <= 1'b0;
         x_re      <= '0;
         x_im      <= '0;
         y_re      <= '0;
         y_im      <= '0;
         ar        <= '0;
         ai        <= '0;
         br        <= '0;
         bi        <= '0;
      end else begin
         if (state inside {OP0, OP1, OP2, OP3}) cnt <= last ? '0 : cnt + 1'b1;
         case (state)
            IDLE: if (in_valid) begin
               ar       <= a_re;
               ai       <= a_im;
               br       <= wb_re;
               bi       <= wb_im;
               add_a    <= a_re;
               add_b    <= wb_re;
               add_sub  <= 1'b0;
               in_ready <= 1'b0;
               busy     <= 1'b1;
               state    <= OP0;
            end
            OP0: if (last) begin
               x_re  <= add_res;
               add_a <= ai;
               add_b <= bi;
               state <= OP1;
            end
            OP1: if (last) begin
               x_im    <= add_res;
               add_a   <= ar;
               add_b   <= br;
               add_sub <= 1'b1;
               state   <= OP2;
            end
            OP2: if (last) begin
               y_re  <= add_res;
               add_a <= ai;
               add_b <= bi;
               state <= OP3;
            end
            OP3: if (last) begin
               y_im      <= add_res;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fft_bfly_addsub_seq.sv
// tb_fft_bfly_addsub_seq: checks the butterfly sequencer at ADD_LAT=0 and ADD_LAT=2 against a float reference
module tb_fft_bfly_addsub_seq;
   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready;
   logic [31:0] a_re, a_im, wb_re, wb_im;
   logic        in_ready0, add_sub0, out_valid0, busy0;
   logic [31:0] add_a0, add_b0, add_res0, x_re0, x_im0, y_re0, y_im0;
   logic        in_ready2, add_sub2, out_valid2, busy2;
   logic [31:0] add_a2, add_b2, add_res2, x_re2, x_im2, y_re2, y_im2;
   logic [31:0] p1, p2;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   fft_bfly_addsub_seq #(.DATA_W(32), .ADD_LAT(0)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .a_re(a_re), .a_im(a_im), .wb_re(wb_re), .wb_im(wb_im),
      .add_a(add_a0), .add_b(add_b0), .add_sub(add_sub0), .add_res(add_res0),
      .out_valid(out_valid0), .out_ready(out_ready),
      .x_re(x_re0), .x_im(x_im0), .y_re(y_re0), .y_im(y_im0), .busy(busy0));

   fft_bfly_addsub_seq #(.DATA_W(32), .ADD_LAT(2)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .a_re(a_re), .a_im(a_im), .wb_re(wb_re), .wb_im(wb_im),
      .add_a(add_a2), .add_b(add_b2), .add_sub(add_sub2), .add_res(add_res2),
      .out_valid(out_valid2), .out_ready(out_ready),
      .x_re(x_re2), .x_im(x_im2), .y_re(y_re2), .y_im(y_im2), .busy(busy2));

   function automatic logic [63:0] f2d(input logic [31:0] f);
      if (f[30:0] == 31'b0) return {f[31], 63'b0};
      return {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0};
   endfunction

   function automatic logic [31:0] d2f(input logic [63:0] d);
      logic [10:0] e;
      e = d[62:52];
      if (e <= 11'd896 || e >= 11'd1151) return {d[63], 31'b0};
      return {d[63], 8'(e - 11'd896), d[51:29]};
   endfunction

   // single-precision add/sub with truncation; any exponent-255 operand yields 0
   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic sub);
      real r;
      if (&a[30:23] || &b[30:23]) return 32'b0;
      r = sub ? $bitstoreal(f2d(a)) - $bitstoreal(f2d(b)) : $bitstoreal(f2d(a)) + $bitstoreal(f2d(b));
      return d2f($realtobits(r));
   endfunction

   function automatic logic [31:0] rnd_f();
      return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
   endfunction

   always_comb add_res0 = fadd(add_a0, add_b0, add_sub0);
   assign add_res2 = p2;
   always_ff @(posedge clk) begin
      p1 <= fadd(add_a2, add_b2, add_sub2);
      p2 <= p1;
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (2) cyc();
      rst = 1'b0;
   endtask

   task automatic randomize_ops();
      a_re = rnd_f();
      a_im = rnd_f();
      wb_re = rnd_f();
      wb_im = rnd_f();
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (in_ready0 !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready0); end
      n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy0); end
      n_cmp++; if (out_valid0 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid0); end
      n_cmp++; if ({add_a0, add_b0, add_sub0} !== 65'b0) begin n_bad++; $display("FAIL reset_adder_ports got %h %h %b want 0", add_a0, add_b0, add_sub0); end
      n_cmp++; if ({x_re0, x_im0, y_re0, y_im0} !== 128'b0) begin n_bad++; $display("FAIL reset_results got %h want 0", {x_re0, x_im0, y_re0, y_im0}); end
      n_cmp++; if ({in_ready2, busy2, out_valid2} !== 3'b100) begin n_bad++; $display("FAIL reset_lat2 got %b want 100", {in_ready2, busy2, out_valid2}); end
   endtask

   task automatic test_basic();
      int got;
      logic [3:0] subs;
      do_reset();
      a_re = 32'h3F800000; a_im = 32'h40000000; wb_re = 32'h3F000000; wb_im = 32'h3F000000;
      in_valid = 1'b1;
      got = 0;
      subs = 4'b0;
      for (int k = 1; k <= 10 && got == 0; k++) begin
         cyc();
         in_valid = 1'b0;
         if (k <= 4) subs[k-1] = add_sub0;
         if (out_valid0) got = k;
      end
      n_cmp++; if (got !== 5) begin n_bad++; $display("FAIL basic_latency got %0d want 5", got); end
      n_cmp++; if (subs !== 4'b1100) begin n_bad++; $display("FAIL basic_add_sub_seq got %b want 1100", subs); end
      n_cmp++; if ({x_re0, x_im0} !== {32'h3FC00000, 32'h40200000}) begin n_bad++; $display("FAIL basic_x got %h %h want 3fc00000 40200000", x_re0, x_im0); end
      n_cmp++; if ({y_re0, y_im0} !== {32'h3F000000, 32'h3FC00000}) begin n_bad++; $display("FAIL basic_y got %h %h want 3f000000 3fc00000", y_re0, y_im0); end
      n_cmp++; if (in_ready0 !== 1'b0) begin n_bad++; $display("FAIL basic_in_ready_done got %b want 0", in_ready0); end
   endtask

   task automatic test_lat2();
      int got, unstable;
      logic [31:0] ea, eb;
      do_reset();
      a_re = 32'h3F800000; a_im = 32'h40000000; wb_re = 32'h3F000000; wb_im = 32'h3F000000;
      in_valid = 1'b1;
      got = 0;
      unstable = 0;
      for (int k = 1; k <= 20 && got == 0; k++) begin
         cyc();
         in_valid = 1'b0;
         if (k <= 12) begin
            ea = (((k - 1) / 3) % 2 != 0) ? 32'h40000000 : 32'h3F800000;
            eb = 32'h3F000000;
            if (add_a2 !== ea || add_b2 !== eb || add_sub2 !== (k > 6)) unstable++;
         end
         if (out_valid2) got = k;
      end
      n_cmp++; if (got !== 13) begin n_bad++; $display("FAIL lat2_latency got %0d want 13", got); end
      n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL lat2_operand_hold got %0d bad cycles want 0", unstable); end
      n_cmp++; if ({x_re2, x_im2, y_re2, y_im2} !== {32'h3FC00000, 32'h40200000, 32'h3F000000, 32'h3FC00000})
         begin n_bad++; $display("FAIL lat2_results got %h want 3fc0000040200000 3f0000003fc00000", {x_re2, x_im2, y_re2, y_im2}); end
   endtask

   task automatic test_backpressure();
      int got, bad;
      logic [31:0] ar, ai, br, bi;
      logic [127:0] snap;
      do_reset();
      randomize_ops();
      ar = a_re; ai = a_im; br = wb_re; bi = wb_im;
      in_valid = 1'b1;
      got = 0;
      for (int k = 1; k <= 10 && got == 0; k++) begin
         cyc();
         in_valid = 1'b0;
         if (out_valid0) got = k;
      end
      n_cmp++; if (got !== 5) begin n_bad++; $display("FAIL bp_latency got %0d want 5", got); end
      n_cmp++; if ({x_re0, x_im0, y_re0, y_im0} !== {fadd(ar, br, 1'b0), fadd(ai, bi, 1'b0), fadd(ar, br, 1'b1), fadd(ai, bi, 1'b1)})
         begin n_bad++; $display("FAIL bp_results got %h want %h", {x_re0, x_im0, y_re0, y_im0},
            {fadd(ar, br, 1'b0), fadd(ai, bi, 1'b0), fadd(ar, br, 1'b1), fadd(ai, bi, 1'b1)}); end
      snap = {x_re0, x_im0, y_re0, y_im0};
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         randomize_ops();
         in_valid = 1'b1;
         cyc();
         if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0 || {x_re0, x_im0, y_re0, y_im0} !== snap) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
      in_valid = 1'b0;
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      n_cmp++; if ({out_valid0, in_ready0, busy0} !== 3'b010) begin n_bad++; $display("FAIL bp_release got %b want 010", {out_valid0, in_ready0, busy0}); end
   endtask

   task automatic test_back_to_back();
      logic [127:0] q[$];
      logic [127:0] e;
      logic acc;
      int last_acc, gap_bad, res_bad, n_acc, n_out;
      do_reset();
      randomize_ops();
      in_valid = 1'b1;
      out_ready = 1'b1;
      last_acc = -1; gap_bad = 0; res_bad = 0; n_acc = 0; n_out = 0;
      for (int c = 0; c < 70; c++) begin
         acc = in_ready0;
         if (acc) begin
            q.push_back({fadd(a_re, wb_re, 1'b0), fadd(a_im, wb_im, 1'b0), fadd(a_re, wb_re, 1'b1), fadd(a_im, wb_im, 1'b1)});
            if (last_acc >= 0 && c - last_acc != 6) gap_bad++;
            last_acc = c;
            n_acc++;
         end
         if (out_valid0) begin
            e = (q.size() > 0) ? q.pop_front() : 128'bx;
            if ({x_re0, x_im0, y_re0, y_im0} !== e) res_bad++;
            n_out++;
         end
         cyc();
         if (acc) randomize_ops();
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      n_cmp++; if (gap_bad !== 0) begin n_bad++; $display("FAIL b2b_spacing got %0d bad gaps want 0", gap_bad); end
      n_cmp++; if (res_bad !== 0) begin n_bad++; $display("FAIL b2b_results got %0d wrong want 0", res_bad); end
      n_cmp++; if (n_acc !== 12 || n_out !== 11) begin n_bad++; $display("FAIL b2b_counts got %0d/%0d want 12/11", n_acc, n_out); end
   endtask

   task automatic test_reset_mid();
      int bad;
      do_reset();
      randomize_ops();
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      repeat (2) cyc();
      n_cmp++; if (busy0 !== 1'b1 || add_sub0 !== 1'b1) begin n_bad++; $display("FAIL mid_in_op2 got busy=%b sub=%b want 1 1", busy0, add_sub0); end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      n_cmp++; if ({out_valid0, busy0, in_ready0} !== 3'b001) begin n_bad++; $display("FAIL mid_reset_state got %b want 001", {out_valid0, busy0, in_ready0}); end
      n_cmp++; if ({x_re0, x_im0} !== 64'b0) begin n_bad++; $display("FAIL mid_reset_x got %h want 0", {x_re0, x_im0}); end
      out_ready = 1'b1;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (out_valid0 !== 1'b0) bad++;
      end
      out_ready = 1'b0;
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL mid_no_stale got %0d valid cycles want 0", bad); end
   endtask

   task automatic test_inf();
      int got;
      do_reset();
      randomize_ops();
      a_re = 32'h7F800000;
      in_valid = 1'b1;
      got = 0;
      for (int k = 1; k <= 10 && got == 0; k++) begin
         cyc();
         in_valid = 1'b0;
         if (out_valid0) got = k;
      end
      n_cmp++; if (got !== 5) begin n_bad++; $display("FAIL inf_latency got %0d want 5", got); end
      n_cmp++; if ({x_re0, y_re0} !== 64'b0) begin n_bad++; $display("FAIL inf_real got %h %h want 0 0", x_re0, y_re0); end
      n_cmp++; if ({x_im0, y_im0} !== {fadd(a_im, wb_im, 1'b0), fadd(a_im, wb_im, 1'b1)})
         begin n_bad++; $display("FAIL inf_imag got %h %h want %h %h", x_im0, y_im0, fadd(a_im, wb_im, 1'b0), fadd(a_im, wb_im, 1'b1)); end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a_re = 32'b0; a_im = 32'b0; wb_re = 32'b0; wb_im = 32'b0;
      test_reset();
      test_basic();
      test_lat2();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_inf();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
